// File: rtl/flag_pkg.sv
// Shared opcode map, ccr bit positions and interrupt FSM states for the flag controller,
// ALU and decoder.
package flag_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SUB  = 5'b00011;
  localparam logic [4:0] OP_AND  = 5'b00100;
  localparam logic [4:0] OP_OR   = 5'b00101;
  localparam logic [4:0] OP_RLC  = 5'b00110;
  localparam logic [4:0] OP_RRC  = 5'b00111;
  localparam logic [4:0] OP_SETC = 5'b01000;
  localparam logic [4:0] OP_CLRC = 5'b01001;
  localparam logic [4:0] OP_NOT  = 5'b01110;
  localparam logic [4:0] OP_NEG  = 5'b01111;
  localparam logic [4:0] OP_INC  = 5'b10000;
  localparam logic [4:0] OP_DEC  = 5'b10001;
  localparam logic [4:0] OP_JZ   = 5'b10010;
  localparam logic [4:0] OP_JN   = 5'b10011;
  localparam logic [4:0] OP_JC   = 5'b10100;
  localparam logic [4:0] OP_JV   = 5'b10101;
  localparam logic [4:0] OP_LOOP = 5'b10110;
  localparam logic [4:0] OP_RTI  = 5'b11010;

  // ccr is packed {V,C,N,Z}
  localparam int unsigned CCR_Z = 0;
  localparam int unsigned CCR_N = 1;
  localparam int unsigned CCR_C = 2;
  localparam int unsigned CCR_V = 3;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StSave = 2'd1,
    StIsr  = 2'd2
  } flag_state_e;

  function automatic logic writes_zn(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_NOT, OP_NEG, OP_INC, OP_DEC};
  endfunction

  function automatic logic writes_c(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_RLC, OP_RRC, OP_INC, OP_DEC};
  endfunction

  function automatic logic writes_v(input logic [4:0] op);
    return op inside {OP_ADD, OP_SUB, OP_INC, OP_DEC};
  endfunction

endpackage

// File: rtl/br_eval.sv
// Branch-condition evaluation: decides whether a conditional branch or LOOP is taken and
// which ccr bit a taken flag-test branch consumes.
module br_eval
  import flag_pkg::*;
(
  input  logic [4:0] alu_op,
  input  logic [3:0] ccr,
  input  logic       loop_nz,
  output logic       take,
  output logic [3:0] clear_mask
);

  always_comb begin
    take       = 1'b0;
    clear_mask = 4'b0000;
    case (alu_op)
      OP_JZ: if (ccr[CCR_Z]) begin
        take              = 1'b1;
        clear_mask[CCR_Z] = 1'b1;
      end
      OP_JN: if (ccr[CCR_N]) begin
        take              = 1'b1;
        clear_mask[CCR_N] = 1'b1;
      end
      OP_JC: if (ccr[CCR_C]) begin
        take              = 1'b1;
        clear_mask[CCR_C] = 1'b1;
      end
      OP_JV: if (ccr[CCR_V]) begin
        take              = 1'b1;
        clear_mask[CCR_V] = 1'b1;
      end
      OP_LOOP: take = loop_nz;
      default: ;
    endcase
  end

endmodule

// File: rtl/flag_ctrl.sv
// Condition-code register, branch resolution and interrupt flag save/restore.
// Macro FLAG_SHADOW_EN enables the RUN/SAVE/ISR interrupt FSM and the ccr shadow.
module flag_ctrl
  import flag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] alu_op,
  input  logic       ex_valid,
  input  logic       stall,
  input  logic       z_in,
  input  logic       n_in,
  input  logic       c_in,
  input  logic       v_in,
  input  logic       loop_nz,
  input  logic       int_req,
  output logic [3:0] ccr,
  output logic       br_taken,
  output logic       flush,
  output logic       int_ack
);

  logic [3:0] r_ccr, w_ccr_d, w_ccr_op, w_clr;
  logic       r_br, r_ack, w_br_d, w_ack_d;
  logic       w_active, w_take;

  assign w_active = ex_valid & ~stall;

  br_eval u_br_eval (
    .alu_op     (alu_op),
    .ccr        (r_ccr),
    .loop_nz    (loop_nz),
    .take       (w_take),
    .clear_mask (w_clr)
  );

  always_comb begin
    w_ccr_op = r_ccr;
    if (writes_zn(alu_op)) begin
      w_ccr_op[CCR_Z] = z_in;
      w_ccr_op[CCR_N] = n_in;
    end
    if (writes_c(alu_op)) w_ccr_op[CCR_C] = c_in;
    if (writes_v(alu_op)) w_ccr_op[CCR_V] = v_in;
    if (alu_op == OP_SETC) w_ccr_op[CCR_C] = 1'b1;
    if (alu_op == OP_CLRC) w_ccr_op[CCR_C] = 1'b0;
    w_ccr_op = w_ccr_op & ~w_clr;
  end

`ifdef FLAG_SHADOW_EN
  flag_state_e r_state, w_state_d;
  logic [3:0]  r_shadow, w_shadow_d;

  always_comb begin
    w_state_d  = r_state;
    w_shadow_d = r_shadow;
    w_ccr_d    = r_ccr;
    w_br_d     = 1'b0;
    w_ack_d    = 1'b0;
    unique case (r_state)
      StRun: begin
        // The EX op retires before entry, so SAVE sees the post-update ccr.
        if (w_active) begin
          w_ccr_d = w_ccr_op;
          w_br_d  = w_take;
        end
        if (int_req && !stall) w_state_d = StSave;
      end
      StSave: begin
        // The op in EX here is being flushed, so it neither writes flags nor branches.
        w_shadow_d = r_ccr;
        w_ack_d    = 1'b1;
        w_state_d  = StIsr;
      end
      StIsr: begin
        if (w_active) begin
          if (alu_op == OP_RTI) begin
            w_ccr_d   = r_shadow;
            w_state_d = StRun;
          end else begin
            w_ccr_d = w_ccr_op;
            w_br_d  = w_take;
          end
        end
      end
      default: w_state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= StRun;
      r_shadow <= 4'b0000;
    end else begin
      r_state  <= w_state_d;
      r_shadow <= w_shadow_d;
    end
  end
`else
  logic w_unused_int_req;
  assign w_unused_int_req = int_req;

  always_comb begin
    w_ccr_d = w_active ? w_ccr_op : r_ccr;
    w_br_d  = w_active & w_take;
    w_ack_d = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ccr <= 4'b0000;
      r_br  <= 1'b0;
      r_ack <= 1'b0;
    end else begin
      r_ccr <= w_ccr_d;
      r_br  <= w_br_d;
      r_ack <= w_ack_d;
    end
  end

  assign ccr      = r_ccr;
  assign br_taken = r_br;
  assign int_ack  = r_ack;
  assign flush    = r_br | r_ack;

endmodule

// File: tb/tb_flag_ctrl.sv
// Scoreboard bench for flag_ctrl: directed scenarios then random traffic against a
// behavioural flag model; interrupt behaviour follows FLAG_SHADOW_EN.
module tb_flag_ctrl;
  import flag_pkg::*;

`ifdef FLAG_SHADOW_EN
  localparam bit ShadowEn = 1'b1;
`else
  localparam bit ShadowEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] alu_op = '0;
  logic       ex_valid = 1'b0, stall = 1'b0;
  logic       z_in = 1'b0, n_in = 1'b0, c_in = 1'b0, v_in = 1'b0;
  logic       loop_nz = 1'b0, int_req = 1'b0;
  logic [3:0] ccr;
  logic       br_taken, flush, int_ack;

  flag_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .alu_op   (alu_op),
    .ex_valid (ex_valid),
    .stall    (stall),
    .z_in     (z_in),
    .n_in     (n_in),
    .c_in     (c_in),
    .v_in     (v_in),
    .loop_nz  (loop_nz),
    .int_req  (int_req),
    .ccr      (ccr),
    .br_taken (br_taken),
    .flush    (flush),
    .int_ack  (int_ack)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] ccr;
    logic       br;
    logic       flush;
    logic       ack;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: individual flags plus interrupt bookkeeping
  bit       m_z, m_n, m_c, m_v;
  bit [3:0] m_shadow;
  bit       m_in_isr, m_save_pending;

  task automatic model_step(input bit rst, input logic [4:0] op, input bit vld, input bit stl,
                            input bit z, input bit n, input bit c, input bit v,
                            input bit lnz, input bit irq);
    bit   active, was_run, br, ack;
    exp_t e;
    active = vld && !stl;
    br     = 1'b0;
    ack    = 1'b0;
    if (!rst) begin
      {m_v, m_c, m_n, m_z} = 4'b0000;
      m_shadow       = 4'b0000;
      m_in_isr       = 1'b0;
      m_save_pending = 1'b0;
    end else if (ShadowEn && m_save_pending) begin
      m_shadow       = {m_v, m_c, m_n, m_z};
      ack            = 1'b1;
      m_save_pending = 1'b0;
      m_in_isr       = 1'b1;
    end else begin
      was_run = !m_in_isr;
      if (active) begin
        if (ShadowEn && m_in_isr && op == OP_RTI) begin
          {m_v, m_c, m_n, m_z} = m_shadow;
          m_in_isr = 1'b0;
        end else begin
          case (op)
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
              m_z = z; m_n = n; m_c = c; m_v = v;
            end
            OP_AND, OP_OR, OP_NOT, OP_NEG: begin
              m_z = z; m_n = n;
            end
            OP_RLC, OP_RRC: m_c = c;
            OP_SETC: m_c = 1'b1;
            OP_CLRC: m_c = 1'b0;
            OP_JZ: if (m_z) begin br = 1'b1; m_z = 1'b0; end
            OP_JN: if (m_n) begin br = 1'b1; m_n = 1'b0; end
            OP_JC: if (m_c) begin br = 1'b1; m_c = 1'b0; end
            OP_JV: if (m_v) begin br = 1'b1; m_v = 1'b0; end
            OP_LOOP: br = lnz;
            default: ;
          endcase
        end
      end
      if (ShadowEn && was_run && irq && !stl) m_save_pending = 1'b1;
    end
    e.ccr   = {m_v, m_c, m_n, m_z};
    e.br    = br;
    e.flush = br | ack;
    e.ack   = ack;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input logic [4:0] op, input bit vld, input bit stl,
                       input bit z, input bit n, input bit c, input bit v,
                       input bit lnz, input bit irq);
    @(negedge clk);
    rst_n = rst; alu_op = op; ex_valid = vld; stall = stl;
    z_in = z; n_in = n; c_in = c; v_in = v; loop_nz = lnz; int_req = irq;
    model_step(rst, op, vld, stl, z, n, c, v, lnz, irq);
  endtask

  task automatic op1(input logic [4:0] op, input bit z, input bit n, input bit c, input bit v);
    drive(1'b1, op, 1'b1, 1'b0, z, n, c, v, 1'b0, 1'b0);
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b1, 5'b00000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: every registered output update is checked against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if ({ccr, br_taken, flush, int_ack} !== e) begin
          n_err++;
          $display("FAIL outputs @%0t: got ccr=%b br=%b flush=%b ack=%b, want ccr=%b br=%b flush=%b ack=%b",
                   $time, ccr, br_taken, flush, int_ack, e.ccr, e.br, e.flush, e.ack);
        end
      end
    end
  end

  initial begin
    drive(1'b0, 5'b00000, 1'b0, 1'b1, 0, 0, 0, 0, 0, 0);
    drive(1'b0, OP_SETC, 1'b1, 1'b0, 0, 0, 0, 0, 0, 1);
    idle(1);

    // ADD flag write
    op1(OP_ADD, 1, 0, 1, 0);
    idle(1);

    // SETC, JC taken and clears C, second JC not taken
    op1(OP_SETC, 0, 0, 0, 0);
    op1(OP_JC, 0, 0, 0, 0);
    op1(OP_JC, 0, 0, 0, 0);
    idle(1);

    // stalled ADD holds, then applies once on release
    for (int i = 0; i < 3; i++) drive(1'b1, OP_ADD, 1'b1, 1'b1, 0, 1, 1, 1, 0, 0);
    op1(OP_ADD, 0, 1, 1, 1);
    idle(1);

    // LOOP taken / not taken
    drive(1'b1, OP_LOOP, 1'b1, 1'b0, 0, 0, 0, 0, 1, 0);
    drive(1'b1, OP_LOOP, 1'b1, 1'b0, 0, 0, 0, 0, 0, 0);

    // ccr=1010, interrupt, ISR modifies flags, RTI restores
    op1(OP_ADD, 0, 1, 0, 1);
    drive(1'b1, 5'b00000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
    idle(2);
    op1(OP_CLRC, 0, 0, 0, 0);
    op1(OP_ADD, 1, 0, 1, 0);
    op1(OP_RTI, 0, 0, 0, 0);
    idle(2);

    // interrupt coincident with DEC setting Z
    drive(1'b1, OP_DEC, 1'b1, 1'b0, 1, 0, 0, 0, 0, 1);
    idle(2);
    op1(OP_ADD, 0, 0, 0, 0);
    op1(OP_RTI, 0, 0, 0, 0);
    idle(1);

    // reset during ISR, later RTI is a no-op
    op1(OP_ADD, 0, 1, 1, 0);
    drive(1'b1, 5'b00000, 1'b0, 1'b0, 0, 0, 0, 0, 0, 1);
    idle(2);
    op1(OP_INC, 1, 1, 1, 1);
    drive(1'b0, OP_INC, 1'b1, 1'b0, 1, 1, 1, 1, 0, 0);
    op1(OP_RTI, 0, 0, 0, 0);
    idle(1);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op;
      op = ($urandom_range(0, 7) == 0) ? OP_RTI : 5'($urandom_range(0, 31));
      drive(($urandom_range(0, 99) != 0), op, ($urandom_range(0, 9) < 8),
            ($urandom_range(0, 4) == 0), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), 1'($urandom), ($urandom_range(0, 19) == 0));
    end

    idle(3);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
